// File: rtl/fifo_rd_stream.sv
// FIFO read-side adapter: issues pops to a one-cycle-latency FIFO and presents the
// returned words as a valid/ready stream through a 3-entry skid buffer.
module fifo_rd_stream #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   empty,
    input  logic [DATA_WIDTH-1:0]  dout,
    input  logic                   valid,
    output logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [1:0]             occupancy,
    output logic [COUNT_WIDTH-1:0] beat_cnt,
    output logic                   err
);

    logic [DATA_WIDTH-1:0] mem [3];
    logic [1:0]            wr_idx;
    logic [1:0]            rd_idx;
    logic [1:0]            occ;
    logic                  inflight;
    logic                  pop;
    logic                  full_block;
    logic                  wr;
    logic                  bad_valid;
    logic [2:0]            committed;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Entries already buffered plus the one still in flight must fit in 3 slots.
    assign committed  = {1'b0, occ} + {2'b00, inflight};
    assign rd_en      = rst_n && enable && !empty && (committed < 3'd3);

    assign m_valid    = (occ != 2'd0);
    assign m_data     = m_valid ? mem[rd_idx] : '0;
    assign occupancy  = occ;

    assign pop        = m_valid && m_ready;
    assign full_block = (occ == 2'd3) && !pop;
    // Unsolicited or overflowing data is flagged and dropped.
    assign bad_valid  = valid && (!inflight || full_block);
    assign wr         = valid && inflight && !full_block;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_idx] <= dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (wr) begin
                wr_idx <= next_idx(wr_idx);
            end
            if (pop) begin
                rd_idx   <= next_idx(rd_idx);
                beat_cnt <= beat_cnt + COUNT_WIDTH'(1);
            end
            if (wr && !pop) begin
                occ <= occ + 2'd1;
            end else if (pop && !wr) begin
                occ <= occ - 2'd1;
            end
            if (bad_valid) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: queue-based reference model, per-cycle
// compare on the falling edge, directed scenarios followed by randomized traffic.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic          empty = 1'b1;
    logic [DW-1:0] dout = '0;
    logic          valid = 1'b0;
    logic          m_ready = 1'b0;
    logic          rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic [1:0]    occupancy;
    logic [CW-1:0] beat_cnt;
    logic          err;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .empty(empty), .dout(dout),
        .valid(valid), .rd_en(rd_en), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .occupancy(occupancy), .beat_cnt(beat_cnt), .err(err)
    );

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;

    // Reference model: buffered words, in-flight flag, beat count, sticky error,
    // plus the upstream FIFO contents and its pending read response.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] fq[$];
    logic [DW-1:0] got[$];
    bit            m_infl = 0;
    bit            m_err = 0;
    logic [CW-1:0] m_cnt = '0;
    bit            pend_v = 0;
    logic [DW-1:0] pend_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic          e_rd;
        logic [DW-1:0] e_md;
        e_rd = rst_n && enable && !empty && ((mq.size() + int'(m_infl)) < 3);
        e_md = (mq.size() != 0) ? mq[0] : '0;
        chk("rd_en", 32'(rd_en), 32'(e_rd));
        chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
        chk("m_data", 32'(m_data), 32'(e_md));
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
        chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
        chk("err", 32'(err), 32'(m_err));
        if (rd_en) rd_pulses++;
        if (m_valid && m_ready) got.push_back(m_data);
    end

    task automatic model_reset();
        mq.delete();
        m_infl = 0;
        m_err  = 0;
        m_cnt  = '0;
        pend_v = 0;
    endtask

    task automatic model_update();
        bit e_rd;
        bit pop;
        bit acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_rd = enable && !empty && ((mq.size() + int'(m_infl)) < 3);
        pop  = (mq.size() != 0) && m_ready;
        acc  = 0;
        if (valid) begin
            if (!m_infl || (mq.size() == 3 && !pop)) m_err = 1;
            else acc = 1;
        end
        if (pop) begin
            void'(mq.pop_front());
            m_cnt = m_cnt + 1'b1;
        end
        if (acc) mq.push_back(dout);
        m_infl = e_rd;
        pend_v = e_rd && (fq.size() != 0);
        if (pend_v) pend_d = fq.pop_front();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        valid = pend_v;
        dout  = pend_v ? pend_d : '0;
        empty = (fq.size() == 0);
    endtask

    task automatic load(input logic [DW-1:0] w);
        fq.push_back(w);
        empty = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        valid = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();
        tick();
        tick();

        // Fill/stream: first word two cycles after enable, then one per cycle.
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        enable = 1'b1;
        m_ready = 1'b1;
        tick();
        chk("fill_lat_mvalid", 32'(m_valid), 32'd0);
        tick();
        chk("fill_w0", 32'(m_data), 32'h11);
        tick();
        chk("fill_w1", 32'(m_data), 32'h22);
        tick();
        chk("fill_w2", 32'(m_data), 32'h33);
        tick();
        chk("fill_w3", 32'(m_data), 32'h44);
        repeat (3) tick();
        chk("fill_beats", 32'(beat_cnt), 32'd4);
        chk("fill_err", 32'(err), 32'd0);

        // Backpressure: three pops only, head held, then full in-order drain.
        m_ready = 1'b0;
        got.delete();
        rd_pulses = 0;
        for (int i = 0; i < 5; i++) load(8'hA1 + 8'(i));
        repeat (8) tick();
        chk("bp_rd_pulses", 32'(rd_pulses), 32'd3);
        chk("bp_occupancy", 32'(occupancy), 32'd3);
        chk("bp_head", 32'(m_data), 32'hA1);
        m_ready = 1'b1;
        repeat (10) tick();
        chk("bp_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("bp_order", 32'(got[i]), 32'hA1 + 32'(i));

        // Enable drop one cycle after a pop request.
        got.delete();
        load(8'hB1); load(8'hB2); load(8'hB3);
        tick();
        enable = 1'b0;
        rd_pulses = 0;
        repeat (5) tick();
        chk("drop_rd_pulses", 32'(rd_pulses), 32'd0);
        chk("drop_count", 32'(got.size()), 32'd1);
        chk("drop_word", 32'(got[0]), 32'hB1);
        chk("drop_occupancy", 32'(occupancy), 32'd0);
        fq.delete();
        empty = 1'b1;

        // Unsolicited data.
        valid = 1'b1;
        dout  = 8'hEE;
        tick();
        chk("unsol_err", 32'(err), 32'd1);
        chk("unsol_occupancy", 32'(occupancy), 32'd0);
        repeat (3) tick();
        chk("unsol_sticky", 32'(err), 32'd1);

        // Reset mid-stream with two words buffered.
        load(8'hC1); load(8'hC2);
        enable = 1'b1;
        m_ready = 1'b0;
        repeat (4) tick();
        chk("mid_occupancy", 32'(occupancy), 32'd2);
        chk("mid_beats", 32'(beat_cnt), 32'd10);
        do_reset();
        enable = 1'b0;
        fq.delete();
        empty = 1'b1;
        valid = 1'b1;
        dout  = 8'h5A;
        tick();
        chk("post_rst_valid_err", 32'(err), 32'd1);
        chk("post_rst_occupancy", 32'(occupancy), 32'd0);
        do_reset();

        // Counter wrap at 4 bits with fresh data after reset.
        got.delete();
        for (int i = 0; i < 17; i++) load(8'h40 + 8'(i));
        enable = 1'b1;
        m_ready = 1'b1;
        repeat (25) tick();
        chk("wrap_beats", 32'(beat_cnt), 32'd1);
        chk("wrap_count", 32'(got.size()), 32'd17);
        for (int i = 0; i < 17; i++) chk("wrap_order", 32'(got[i]), 32'h40 + 32'(i));
        enable = 1'b0;
        do_reset();

        for (int c = 0; c < 3000; c++) begin
            tick();
            enable  = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 4) > 1);
            if (fq.size() < 4 && $urandom_range(0, 2) == 0) load(DW'($urandom));
            if (!pend_v && $urandom_range(0, 249) == 0) begin
                valid = 1'b1;
                dout  = DW'($urandom);
            end
            if ($urandom_range(0, 399) == 0) do_reset();
        end

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
